// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: configuration handshake for seq_det_ctrl
interface seq_det_ctrl_if #(parameter int CNT_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  modport master(output cfg_valid, cfg_pattern, cfg_target, input cfg_ready);
  modport slave(input cfg_valid, cfg_pattern, cfg_target, output cfg_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-controlled overlapping 4-bit serial pattern detector with match counter
module seq_det_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_det_ctrl_if.slave    cfg,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [3:0]       pattern_reg;
  logic [CNT_W-1:0] target_reg;
  logic [2:0]       hist;
  logic [1:0]       fill;
  logic             hit_target;
  logic             restart;
  assign z           = state == RUN && x_valid && fill == 2'd3 && {hist, x} == pattern_reg;
  assign hit_target  = z && target_reg != '0 && match_count + CNT_W'(1) == target_reg;
  assign restart     = start && (state == IDLE || (state == DONE && !stop));
  assign cfg.cfg_ready = state == IDLE;
  assign busy        = state == RUN;
  assign done        = state == DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pattern_reg <= 4'b0101;
      target_reg  <= '0;
      match_count <= '0;
      hist        <= '0;
      fill        <= '0;
    end else begin
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        pattern_reg <= cfg.cfg_pattern;
        target_reg  <= cfg.cfg_target;
      end
      if (restart) begin
        state       <= RUN;
        match_count <= '0;
        hist        <= '0;
        fill        <= '0;
      end else if (state == DONE && stop) begin
        state <= IDLE;
      end else if (state == RUN) begin
        if (x_valid) begin
          hist <= {hist[1:0], x};
          fill <= fill == 2'd3 ? fill : fill + 2'd1;
        end
        // stop beats reaching the target; the count still records the match
        if (z && !(&match_count)) match_count <= match_count + CNT_W'(1);
        state <= stop ? IDLE : hit_target ? DONE : RUN;
      end
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench comparing seq_det_ctrl against a behavioural model
module tb_seq_det_ctrl;
  logic       clk = 0;
  logic       reset = 0;
  logic       start = 0, stop = 0, x = 0, x_valid = 0;
  logic       z, busy, done;
  logic [7:0] match_count;
  int         n_tests = 0, n_fail = 0;
  int         m_state, m_pat, m_tgt, m_cnt, m_hist, m_nv;
  bit         exp_q[$];
  seq_det_ctrl_if #(.CNT_W(8)) cfg_if ();
  seq_det_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg(cfg_if.slave), .start(start), .stop(stop),
    .x(x), .x_valid(x_valid), .z(z), .match_count(match_count), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic s, input logic st, input logic xv, input logic xb,
                      input logic cv = 0, input logic [3:0] cp = 0, input logic [7:0] ct = 0);
    bit ez, hit;
    @(negedge clk);
    start = s; stop = st; x_valid = xv; x = xb;
    cfg_if.cfg_valid = cv; cfg_if.cfg_pattern = cp; cfg_if.cfg_target = ct;
    ez = m_state == 1 && xv && m_nv >= 3 && ((((m_hist << 1) | int'(xb)) & 15) == m_pat);
    exp_q.push_back(ez);
    #1;
    check("z", z, exp_q.pop_front());
    check("cfg_ready", cfg_if.cfg_ready, m_state == 0);
    case (m_state)
      0: begin
        if (cv) begin m_pat = cp; m_tgt = ct; end
        if (s) begin m_state = 1; m_cnt = 0; m_hist = 0; m_nv = 0; end
      end
      1: begin
        hit = ez && m_tgt != 0 && m_cnt + 1 == m_tgt;
        if (xv) begin m_hist = ((m_hist << 1) | int'(xb)) & 7; if (m_nv < 3) m_nv++; end
        if (ez && m_cnt < 255) m_cnt++;
        if (st) m_state = 0;
        else if (hit) m_state = 2;
      end
      default: begin
        if (st) m_state = 0;
        else if (s) begin m_state = 1; m_cnt = 0; m_hist = 0; m_nv = 0; end
      end
    endcase
    @(posedge clk);
    #1;
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("count", match_count, m_cnt);
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 0, 1, v[i]);
  endtask
  task automatic hit_reset();
    start = 0; stop = 0; cfg_if.cfg_valid = 0;
    reset = 0;
    #1;
    m_state = 0; m_pat = 5; m_tgt = 0; m_cnt = 0; m_hist = 0; m_nv = 0;
    check("rst_z", z, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    check("rst_count", match_count, 0);
    x_valid = 1; x = 1;
    #1;
    check("rst_z_held", z, 0);
    @(negedge clk);
    reset = 1;
  endtask
  initial begin
    cfg_if.cfg_valid = 0; cfg_if.cfg_pattern = 0; cfg_if.cfg_target = 0;
    #2;
    hit_reset();
    step(1, 0, 0, 0);
    send(32'b010101, 6);
    check("r36_count", match_count, 2);
    check("r36_busy", busy, 1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 4'b1001, 8'd2);
    send(32'b10010011, 8);
    check("r37_done", done, 1);
    send(32'b1, 1);
    check("r37_count", match_count, 2);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 4'b0101, 8'd0);
    step(0, 0, 1, 0); step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 1);
    check("r38_count", match_count, 1);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    send(32'b010, 3);
    step(0, 1, 1, 1);
    check("r39_count", match_count, 1);
    check("r39_idle", {busy, done}, 2'b00);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'b1111, 8'd0);
    send(32'b11110101, 8);
    check("r41_count", match_count, 1);
    send(32'b010, 3);
    hit_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 610; i++) step(0, 0, 1, i[0]);
    check("r40_sat", match_count, 255);
    check("r40_busy", busy, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("idle_start_wins", busy, 1);
    step(1, 1, 1, 0);
    check("run_stop_wins", busy, 0);
    step(1, 0, 0, 0, 1, 4'b0101, 8'd1);
    send(32'b0101, 4);
    check("tgt1_done", done, 1);
    send(32'b0101, 4);
    step(1, 0, 1, 1);
    check("done_restart", {busy, match_count}, 9'h100);
    send(32'b0101, 4);
    step(1, 1, 0, 0);
    check("done_stop_wins", {busy, done}, 2'b00);
    step(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
